// File: rtl/z80_bus_pkg.sv
// Shared constants for the Z80 bus bridge and its decoder.
package z80_bus_pkg;

  localparam int WIN_W = 4;

  localparam logic [7:0] RD_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/z80_bus_decode.sv
// Strobe and window decode for the synchronous Z80 bus.
module z80_bus_decode
  import z80_bus_pkg::*;
#(
  parameter logic [WIN_W-1:0] MEM_BASE = 4'hF,
  parameter logic [WIN_W-1:0] IO_BASE  = 4'h8
) (
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [15:0] A,
  output logic        strobe,
  output logic        hit_mem,
  output logic        hit_io,
  output logic        sel
);

  logic unused_a;

  assign unused_a = ^{A[11:8], A[3:0]};

  assign strobe = (!rd_n || !wr_n) &&
                  (!mreq_n || !iorq_n);

  assign hit_mem = !mreq_n &&
                   (A[15:12] == MEM_BASE);

  // m1_n low with iorq_n is interrupt acknowledge
  assign hit_io = !iorq_n && m1_n &&
                  (A[7:4] == IO_BASE);

  assign sel = strobe && (hit_mem || hit_io);

endmodule

// File: rtl/z80_bus_bridge.sv
// Z80 strobes to req/ack peripheral handshake with wait_n stretch.
// Optional REQ timeout: define BRIDGE_TIMEOUT_EN.
module z80_bus_bridge
  import z80_bus_pkg::*;
#(
  parameter logic [WIN_W-1:0] MEM_BASE = 4'hF,
  parameter logic [WIN_W-1:0] IO_BASE  = 4'h8,
  parameter int               TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        wait_n,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_io,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic        bus_ack,
  input  logic [7:0]  bus_rdata,
  output logic        bus_err
);

  state_t      state, state_nxt;
  logic        strobe, hit_mem, hit_io, sel;
  logic        unused_hit;
  logic        tmo;
  logic        req_nxt, we_nxt, io_nxt, err_nxt;
  logic [15:0] addr_nxt;
  logic [7:0]  wdata_nxt, din_nxt;

  z80_bus_decode #(
    .MEM_BASE (MEM_BASE),
    .IO_BASE  (IO_BASE)
  ) u_decode (
    .m1_n    (m1_n),
    .mreq_n  (mreq_n),
    .iorq_n  (iorq_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .A       (A),
    .strobe  (strobe),
    .hit_mem (hit_mem),
    .hit_io  (hit_io),
    .sel     (sel)
  );

  assign unused_hit = hit_mem;

  // Combinational so the core holds T2 in the strobe cycle
  assign wait_n = ~(sel && (state != DONE));

`ifdef BRIDGE_TIMEOUT_EN
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)
      cnt <= '0;
    else if (state == REQ)
      cnt <= cnt + 8'd1;
    else
      cnt <= '0;
  end

  assign tmo = (cnt == 8'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    req_nxt   = bus_req;
    we_nxt    = bus_we;
    io_nxt    = bus_io;
    addr_nxt  = bus_addr;
    wdata_nxt = bus_wdata;
    din_nxt   = cpu_din;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (sel) begin
          addr_nxt  = A;
          wdata_nxt = cpu_dout;
          we_nxt    = ~wr_n;
          io_nxt    = hit_io;
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // An ack coinciding with expiry completes normally
        if (bus_ack) begin
          req_nxt   = 1'b0;
          if (!bus_we)
            din_nxt = bus_rdata;
          state_nxt = DONE;
        end else if (tmo) begin
          req_nxt   = 1'b0;
          if (!bus_we)
            din_nxt = RD_DEFAULT;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!strobe)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_io    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      cpu_din   <= RD_DEFAULT;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bus_req   <= req_nxt;
      bus_we    <= we_nxt;
      bus_io    <= io_nxt;
      bus_addr  <= addr_nxt;
      bus_wdata <= wdata_nxt;
      cpu_din   <= din_nxt;
      bus_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Directed bench for z80_bus_bridge.
module tb_z80_bus_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m1_n, mreq_n, iorq_n;
  logic        rd_n, wr_n;
  logic [15:0] A;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        wait_n;
  logic        bus_req, bus_we, bus_io;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack;
  logic [7:0]  bus_rdata;
  logic        bus_err;

  int n_chk = 0;
  int n_err = 0;
  int stretch = 0;
  int req_cyc = 0;
  int acks = 0;

  always #5 clk = ~clk;

  z80_bus_bridge dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m1_n      (m1_n),
    .mreq_n    (mreq_n),
    .iorq_n    (iorq_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .A         (A),
    .cpu_dout  (cpu_dout),
    .cpu_din   (cpu_din),
    .wait_n    (wait_n),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_io    (bus_io),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .bus_err   (bus_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Sample pre-edge activity, then advance past the edge
  task automatic step();
    #1;
    if (!wait_n) stretch++;
    if (bus_req) req_cyc++;
    if (bus_req && bus_ack) acks++;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_bus();
    m1_n   = 1'b1;
    mreq_n = 1'b1;
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
  endtask

  task automatic clr_stats();
    stretch = 0;
    req_cyc = 0;
    acks    = 0;
  endtask

  initial begin
    reset_n   = 1'b0;
    idle_bus();
    A         = 16'h0000;
    cpu_dout  = 8'h00;
    bus_ack   = 1'b0;
    bus_rdata = 8'h00;
    step();
    step();
    reset_n = 1'b1;
    #1;
    check("rst_req", bus_req, 0);
    check("rst_wait", wait_n, 1);
    check("rst_din", cpu_din, 8'hFF);
    check("rst_addr", bus_addr, 0);
    check("rst_we_io", {bus_we, bus_io}, 0);
    check("rst_err", bus_err, 0);

    // memory read, ack in third REQ cycle
    clr_stats();
    A = 16'hF123;
    mreq_n = 1'b0;
    rd_n = 1'b0;
    #1;
    check("mr_wait_t2", wait_n, 0);
    check("mr_req_t2", bus_req, 0);
    step();
    check("mr_req", bus_req, 1);
    check("mr_io_we", {bus_io, bus_we}, 0);
    check("mr_addr", bus_addr, 16'hF123);
    step();
    step();
    check("mr_hold", {bus_req, wait_n}, 2'b10);
    bus_ack = 1'b1;
    bus_rdata = 8'h5A;
    step();
    bus_ack = 1'b0;
    check("mr_done_wait", wait_n, 1);
    check("mr_din", cpu_din, 8'h5A);
    check("mr_req_off", bus_req, 0);
    check("mr_stretch", stretch, 4);
    idle_bus();
    step();

    // I/O write with immediate ack
    clr_stats();
    A = 16'h3384;
    cpu_dout = 8'hC3;
    iorq_n = 1'b0;
    wr_n = 1'b0;
    step();
    check("iow_req", bus_req, 1);
    check("iow_io_we", {bus_io, bus_we}, 2'b11);
    check("iow_addr", bus_addr[7:0], 8'h84);
    check("iow_wdata", bus_wdata, 8'hC3);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    check("iow_wait", wait_n, 1);
    check("iow_din_keep", cpu_din, 8'h5A);
    check("iow_req_cyc", req_cyc, 1);
    check("iow_stretch", stretch, 2);
    idle_bus();
    step();

    // unselected accesses; stray ack while idle
    clr_stats();
    A = 16'h1000;
    mreq_n = 1'b0;
    rd_n = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 8'hEE;
    step();
    step();
    bus_ack = 1'b0;
    idle_bus();
    step();
    A = 16'h0010;
    iorq_n = 1'b0;
    rd_n = 1'b0;
    step();
    step();
    idle_bus();
    step();
    A = 16'h0080;
    m1_n = 1'b0;
    iorq_n = 1'b0;
    rd_n = 1'b0;
    step();
    step();
    idle_bus();
    step();
    check("uns_stretch", stretch, 0);
    check("uns_req", req_cyc, 0);
    check("uns_din", cpu_din, 8'h5A);

    // back-to-back reads, strobes held in DONE
    clr_stats();
    A = 16'hF010;
    mreq_n = 1'b0;
    rd_n = 1'b0;
    step();
    bus_ack = 1'b1;
    bus_rdata = 8'h11;
    step();
    bus_ack = 1'b0;
    check("b2b_din1", cpu_din, 8'h11);
    step();
    step();
    check("b2b_hold", {bus_req, wait_n}, 2'b01);
    idle_bus();
    step();
    A = 16'hF011;
    mreq_n = 1'b0;
    rd_n = 1'b0;
    step();
    check("b2b_req2", bus_req, 1);
    bus_ack = 1'b1;
    bus_rdata = 8'h77;
    step();
    bus_ack = 1'b0;
    check("b2b_din2", cpu_din, 8'h77);
    check("b2b_acks", acks, 2);
    idle_bus();
    step();

`ifdef BRIDGE_TIMEOUT_EN
    // read with no ack expires after 16 REQ cycles
    A = 16'hF300;
    mreq_n = 1'b0;
    rd_n = 1'b0;
    step();
    for (int i = 0; i < 15; i++) step();
    check("to_req_last", {bus_req, bus_err}, 2'b10);
    step();
    check("to_err", bus_err, 1);
    check("to_din", cpu_din, 8'hFF);
    check("to_wait", wait_n, 1);
    step();
    check("to_err_pulse", bus_err, 0);
    idle_bus();
    step();

    // ack on the expiry cycle wins
    A = 16'hF301;
    mreq_n = 1'b0;
    rd_n = 1'b0;
    step();
    for (int i = 0; i < 15; i++) step();
    bus_ack = 1'b1;
    bus_rdata = 8'hA5;
    step();
    bus_ack = 1'b0;
    check("toa_err", bus_err, 0);
    check("toa_din", cpu_din, 8'hA5);
    idle_bus();
    step();
`endif

    // reset while in REQ
    A = 16'hF200;
    mreq_n = 1'b0;
    rd_n = 1'b0;
    step();
    check("rr_req", bus_req, 1);
    reset_n = 1'b0;
    idle_bus();
    step();
    reset_n = 1'b1;
    #1;
    check("rr_req_off", bus_req, 0);
    check("rr_wait", wait_n, 1);
    check("rr_din", cpu_din, 8'hFF);
    check("rr_addr", bus_addr, 0);
    bus_ack = 1'b1;
    bus_rdata = 8'h99;
    step();
    bus_ack = 1'b0;
    check("rr_late_ack", {cpu_din, bus_req},
          {8'hFF, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/z80_bus_bridge.md
Name: z80_bus_bridge

Overview:
Downstream stage of the synchronous Z80 core wrapper. Consumes its registered bus strobes (mreq_n/iorq_n/rd_n/wr_n), address and write data.
- Decodes one memory window and one I/O window.
- Converts each matching access into a req/ack handshake towards a slow peripheral fabric.
- Stretches the CPU cycle via wait_n until the peripheral acknowledges, then returns read data.

Parameters:
- MEM_BASE, 4'hF: matched against A[15:12] for memory accesses (4 KiB window).
- IO_BASE, 4'h8: matched against A[7:4] for I/O accesses (16-port window).
- TIMEOUT, 16: REQ-state cycle limit; used only with BRIDGE_TIMEOUT_EN; legal range 2..255.

Ports:
- clk, input, 1: clock, same clock as the CPU wrapper.
- reset_n, input, 1: synchronous, active-low reset.
- m1_n, input, 1: CPU M1; low with iorq_n marks interrupt acknowledge.
- mreq_n, input, 1: CPU memory request.
- iorq_n, input, 1: CPU I/O request.
- rd_n, input, 1: CPU read strobe.
- wr_n, input, 1: CPU write strobe.
- A, input, 16: CPU address.
- cpu_dout, input, 8: CPU write data.
- cpu_din, output, 8: read data to CPU data_in.
- wait_n, output, 1: to CPU wait_n; combinational.
- bus_req, output, 1: peripheral request, registered.
- bus_we, output, 1: 1 = write.
- bus_io, output, 1: 1 = I/O space, 0 = memory.
- bus_addr, output, 16: captured address.
- bus_wdata, output, 8: captured write data.
- bus_ack, input, 1: one-cycle completion pulse from peripheral.
- bus_rdata, input, 8: peripheral read data, valid with bus_ack.
- bus_err, output, 1: timeout pulse; tied 0 without BRIDGE_TIMEOUT_EN.

Behaviour:
Reset values: state IDLE; bus_req 0; bus_we 0; bus_io 0; bus_addr 0; bus_wdata 0; cpu_din 8'hFF; bus_err 0; wait_n 1.

Strobe and decode:
- strobe = (rd_n==0 || wr_n==0) && (mreq_n==0 || iorq_n==0).
- hit_mem = mreq_n==0 && A[15:12]==MEM_BASE.
- hit_io = iorq_n==0 && m1_n==1 && A[7:4]==IO_BASE.
- sel = strobe && (hit_mem || hit_io).
- Interrupt acknowledge (iorq_n==0 && m1_n==0) is never selected.

wait_n = ~(sel && state!=DONE):
- Low in the same cycle the strobes first appear (CPU T2), so the core holds T2.
- No registered delay is permitted here.

State machine (IDLE, REQ, DONE):
- IDLE, sel=1: capture A -> bus_addr, cpu_dout -> bus_wdata, ~wr_n -> bus_we, hit_io -> bus_io; bus_req<=1; go REQ. bus_req rises one cycle after the strobe appears.
- IDLE, sel=0: stay; bus_ack ignored.
- REQ, bus_ack=1: bus_req<=0. If read, cpu_din<=bus_rdata; if write, cpu_din unchanged. Go DONE. bus_ack is accepted the earliest in the first REQ cycle. Minimum wait stretch is 2 cycles (IDLE->REQ, REQ->DONE).
- REQ, bus_ack=0: hold bus_req and all captured fields stable.
- DONE: wait_n=1, so the CPU samples cpu_din this cycle. Stay while strobe=1; go IDLE when strobe=0. Re-entry requires strobes to deassert, so one CPU access equals exactly one bus transaction.

Other rules:
- Unselected accesses: wait_n=1 and no request.
- cpu_din holds its last value. Decode of unselected reads is the top-level mux's job.
- Strobes vanishing during REQ (not legal from the core): transaction completes normally; DONE then exits immediately.
- Reset mid-transaction: every register returns to its reset value next edge; bus_req drops without ack. The peripheral must tolerate an abandoned request.

Optional Feature:
BRIDGE_TIMEOUT_EN
- Defined: an 8-bit counter clears on IDLE->REQ and increments each REQ cycle. When it reaches TIMEOUT-1 with no ack:
  - bus_req<=0;
  - cpu_din<=8'hFF on reads;
  - bus_err pulses 1 for one cycle;
  - go DONE.
- An ack in the same cycle as the expiry wins: normal completion, no bus_err.
- Undefined: no counter; REQ waits indefinitely; bus_err constant 0.

Decomposition:
- Shared package z80_bus_pkg:
  - state encoding localparams (IDLE=2'd0, REQ=2'd1, DONE=2'd2);
  - default read value 8'hFF;
  - window width constants (4-bit high-nibble compare).
- One natural sub-module, z80_bus_decode: purely combinational strobe/hit_mem/hit_io/sel logic. It is reused by other peripherals sharing the CPU bus.
- FSM and capture registers stay in z80_bus_bridge.

Test Plan:
- Memory read A=16'hF123, peripheral acks 3 cycles after bus_req with rdata 8'h5A:
  - wait_n low from strobe cycle until DONE;
  - bus_io=0, bus_we=0;
  - cpu_din=8'h5A while wait_n=1.
- I/O write OUT (8'h84),8'hC3 with immediate ack:
  - bus_req exactly 1 cycle;
  - bus_io=1, bus_we=1, bus_addr[7:0]=8'h84, bus_wdata=8'hC3;
  - total wait stretch 2 cycles.
- Unselected accesses (memory A=16'h1000; I/O A[7:0]=8'h10; interrupt ack with A[7:4]=8): wait_n stays 1, bus_req never asserts.
- Back-to-back selected reads: second bus_req asserts only after the strobes deassert in between; exactly two ack-consumed transactions.
- reset_n low for 1 cycle while in REQ: next cycle bus_req=0, wait_n=1 once strobes clear, cpu_din=8'hFF; a late bus_ack is ignored.
- With BRIDGE_TIMEOUT_EN, TIMEOUT=16, no ack on a read: bus_err pulses once after 16 REQ cycles, cpu_din=8'hFF, wait_n released. Second run with ack on the expiry cycle: no bus_err, rdata returned.
